// File: rtl/core_pkg.sv
// Core-wide constants shared by the memory-side blocks.
package core_pkg;
  localparam int unsigned Xlen = 32;
endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction in flight; LS has priority, bounded by a starvation counter.
module mem_port_arbiter #(
  parameter int unsigned DataWidth   = core_pkg::Xlen,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   if_valid_i,
  input  logic [DataWidth-1:0]   if_addr_i,
  output logic                   if_ready_o,
  output logic                   if_rvalid_o,
  output logic [DataWidth-1:0]   if_rdata_o,
  input  logic                   ls_valid_i,
  input  logic                   ls_we_i,
  input  logic [DataWidth-1:0]   ls_addr_i,
  input  logic [DataWidth-1:0]   ls_wdata_i,
  input  logic [DataWidth/8-1:0] ls_wmask_i,
  output logic                   ls_ready_o,
  output logic                   ls_rvalid_o,
  output logic [DataWidth-1:0]   ls_rdata_o,
  output logic                   mem_valid_o,
  input  logic                   mem_ready_i,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_wmask_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  localparam int unsigned MaskW = DataWidth / 8;
  localparam int unsigned CntW  = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

  typedef enum logic [1:0] {Idle, Req, Resp} state_e;
  typedef enum logic {OwnIf, OwnLs} owner_e;

  typedef struct packed {
    logic                 we;
    logic [DataWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [MaskW-1:0]     wmask;
  } mem_req_t;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic              contested;
  logic              force_if;

  assign contested = if_valid_i & ls_valid_i;
  // With StarveLimit == 0 the counter saturates at 0, so fairness never kicks in.
  assign force_if  = (StarveLimit != 0) && (cnt_q == CntMax);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    if_ready_o = 1'b0;
    ls_ready_o = 1'b0;
    unique case (state_q)
      Idle: begin
        if (ls_valid_i && !(if_valid_i && force_if)) begin
          ls_ready_o = 1'b1;
          owner_d    = OwnLs;
          req_d      = '{we: ls_we_i, addr: ls_addr_i, wdata: ls_wdata_i, wmask: ls_wmask_i};
          if (!contested)           cnt_d = '0;
          else if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
          state_d    = Req;
        end else if (if_valid_i) begin
          if_ready_o = 1'b1;
          owner_d    = OwnIf;
          req_d      = '{we: 1'b0, addr: if_addr_i, wdata: '0, wmask: '0};
          cnt_d      = '0;
          state_d    = Req;
        end
      end
      Req:     if (mem_ready_i)  state_d = Resp;
      Resp:    if (mem_rvalid_i) state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      owner_q <= OwnIf;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign mem_valid_o = (state_q == Req);
  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_wmask_o = req_q.wmask;

  // Responses outside Resp are stray and never reach a requester.
  assign if_rvalid_o = (state_q == Resp) && (owner_q == OwnIf) && mem_rvalid_i;
  assign ls_rvalid_o = (state_q == Resp) && (owner_q == OwnLs) && mem_rvalid_i;
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

endmodule
